// File: rtl/set_bit_scanner.sv
// Serialises the set bits of an accepted vector into a stream of positions,
// lowest first, one per out_valid/out_ready handshake beat.
module set_bit_scanner #(
    parameter int WIDTH = 16,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic [POS_W:0]   out_idx,
    output logic             out_last,
    output logic             done,
    output logic             done_empty
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] VEC_ONE = WIDTH'(1);
    localparam logic [POS_W:0]   CNT_ONE = (POS_W + 1)'(1);

    // Bit b of the encoded position is set for every index whose bit b is 1.
    function automatic logic [WIDTH-1:0] f_pos_mask(input int b);
        logic [WIDTH-1:0] m;
        for (int j = 0; j < WIDTH; j++) begin
            m[j] = ((j >> b) & 1) != 0;
        end
        return m;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [POS_W:0]   r_cnt;
    logic [POS_W:0]   w_cnt_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_done_empty;
    logic             w_done_empty_next;

    logic [WIDTH-1:0] w_onehot;
    logic [POS_W-1:0] w_pos;
    logic             w_last;
    logic             w_emit;

    // Two's-complement trick isolates the lowest set bit; that is exactly 1<<pos.
    assign w_onehot = r_work & (~r_work + VEC_ONE);
    assign w_last   = (r_work & (r_work - VEC_ONE)) == '0;
    assign w_emit   = (r_state == S_EMIT);

    genvar gi;
    generate
        for (gi = 0; gi < POS_W; gi++) begin : g_enc
            assign w_pos[gi] = |(w_onehot & f_pos_mask(gi));
        end
    endgenerate

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = w_emit;
    assign out_pos    = w_emit ? w_pos : '0;
    assign out_idx    = w_emit ? r_cnt : '0;
    assign out_last   = w_emit & w_last;
    assign done       = r_done;
    assign done_empty = r_done_empty;

    always_comb begin
        w_state_next      = r_state;
        w_work_next       = r_work;
        w_cnt_next        = r_cnt;
        w_done_next       = 1'b0;
        w_done_empty_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_work_next = in_vec;
                    w_cnt_next  = '0;
                    if (in_vec == '0) begin
                        w_done_next       = 1'b1;
                        w_done_empty_next = 1'b1;
                    end else begin
                        w_state_next = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_work_next = r_work & ~w_onehot;
                    w_cnt_next  = r_cnt + CNT_ONE;
                    if (w_last) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_work       <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_done_empty <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_work       <= w_work_next;
            r_cnt        <= w_cnt_next;
            r_done       <= w_done_next;
            r_done_empty <= w_done_empty_next;
        end
    end

endmodule

// File: doc/set_bit_scanner.md
Name: set_bit_scanner

Overview:
Sequential inverse of the position-to-mask bit operations. The block accepts a WIDTH-bit vector and emits the index of every set bit, one per handshake beat, in ascending order. After each emitted index it clears that bit internally, using the clear-bit operation `work & ~(1<<pos)`. It sits between a bit-mask producer (request/flag vectors) and a consumer that needs positions, such as an arbiter grant decoder or an interrupt dispatcher.

Parameters:
WIDTH, 16, width of input vector; integer >= 2.
POS_W, $clog2(WIDTH), width of the emitted position; derived, do not override.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  in_vec is valid.
in_ready  output  1  block can accept a vector; high only in IDLE.
in_vec  input  WIDTH  vector to scan.
out_valid  output  1  out_pos/out_idx/out_last valid.
out_ready  input  1  consumer accepts current beat.
out_pos  output  POS_W  index of lowest remaining set bit.
out_idx  output  POS_W+1  ordinal of this beat within the vector, starting at 0.
out_last  output  1  current beat is the final set bit of the vector.
done  output  1  one-cycle pulse when a vector is fully processed.
done_empty  output  1  qualifies done: accepted vector was all zeros.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, work=0, beat counter=0, out_valid=0, done=0, done_empty=0.
  - in_ready=1 the cycle after reset is released.
  - out_pos, out_idx and out_last read 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Accept: an input transfer occurs on a clk edge where in_valid && in_ready.
  - The block registers work <= in_vec and resets the beat counter to 0.
  - If in_vec != 0, go to EMIT; out_valid=1 on the next cycle (1-cycle latency).
  - If in_vec == 0, stay in IDLE; done=1 and done_empty=1 for exactly the next cycle; no output beat.
- EMIT outputs, derived from registered state only (no combinational path from input ports):
  - out_pos = index of the least-significant 1 in work.
  - out_idx = beat counter.
  - out_last = (work & (work-1)) == 0.
- Output transfer occurs on a clk edge where out_valid && out_ready:
  - work <= work & ~(1<<out_pos); the beat counter increments.
  - If out_last: go to IDLE; done=1, done_empty=0 for the next cycle; in_ready=1 in that same cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_pos, out_idx and out_last hold stable. out_valid never drops without a transfer.
- One beat per cycle maximum. A vector with N set bits needs N output transfers.
- Throughput: a new vector can be accepted at the earliest on the cycle after the last beat.
- No overlap: inputs offered while in EMIT are ignored (in_ready=0) and are not latched.
- Input sampling: in_vec is sampled only at acceptance; later changes have no effect.
- Boundary bits: bit 0 gives out_pos=0; bit WIDTH-1 gives out_pos=WIDTH-1.
  - All-ones input gives WIDTH beats, with out_idx running 0..WIDTH-1 and out_last on the final beat.
  - out_idx width POS_W+1 holds values up to WIDTH-1 without wrap.
- done and done_empty are single-cycle pulses and are never asserted back-to-back for one vector.
- Reset mid-operation: the in-flight vector is discarded; no done pulse; the block returns to IDLE per reset values.
- Simultaneous rst_n=0 with any handshake: reset wins.

Test Plan:
- WIDTH=8, in_vec=8'b1010_0100, out_ready=1 -> beats (pos,idx,last) = (2,0,0),(5,1,0),(7,2,1) on consecutive cycles starting 1 cycle after accept; done=1, done_empty=0 the cycle after the last beat; in_ready=1 that cycle.
- Same vector, out_ready toggled 0,0,1,0,1,1 -> outputs hold stable across stalls; the same 3 beats occur in order; no beat lost or duplicated.
- in_vec=0 accepted -> out_valid stays 0; done=1 and done_empty=1 for one cycle, 1 cycle after accept; in_ready stays 1.
- in_vec=8'hFF, out_ready=1 -> 8 beats, pos 0..7, idx 0..7, last only on pos 7; then in_vec=8'h81 offered while EMIT is ignored until IDLE, then yields pos 0 then 7.
- in_vec=8'h80 -> single beat pos=7, idx=0, last=1; then in_vec=8'h01 accepted next cycle -> pos=0, last=1.
- in_vec=8'h0F, after 2 beats assert rst_n=0 for 1 cycle -> out_valid=0, no done; in_ready=1 after release; a new vector 8'h10 yields pos=4, idx=0, last=1.
